// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer slice: FSM state encoding,
// the per-pass shift limit and the width of the per-pass amount.
package shift_seq_pkg;

  // Largest amount a single pass may shift (3-to-8 one-hot decode range).
  localparam int unsigned STEP_MAX = 7;
  // Width of a single pass amount.
  localparam int unsigned STEP_W   = 3;
  // Width of the one-hot pass amount.
  localparam int unsigned ONEHOT_W = 1 << STEP_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One pass of the shifter datapath, purely combinational.
// Ports:
//   operand     - value to shift
//   step_onehot - one-hot pass amount (bit i set = shift by i); all-zero passes through
//   right       - 1 = shift right, 0 = shift left
//   arith       - 1 = sign-fill on right shift; ignored on left shift
//   shifted     - operand shifted by the selected amount
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]    operand,
  input  logic [ONEHOT_W-1:0] step_onehot,
  input  logic                right,
  input  logic                arith,
  output logic [WIDTH-1:0]    shifted
);

  always_comb begin
    shifted = operand;
    for (int unsigned i = 0; i < ONEHOT_W; i++) begin
      if (step_onehot[i]) begin
        if (!right) begin
          shifted = operand << i;
        end else if (arith) begin
          shifted = $signed(operand) >>> i;
        end else begin
          shifted = operand >> i;
        end
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller. Accepts one request at a time, splits the
// total shift amount into passes of at most STEP_MAX bits, applies each pass
// to an internal operand register and returns the result over valid/ready.
// Ports:
//   clk, reset_n               - clock (rising edge), async active-low reset
//   start_valid / start_ready  - request handshake (a, shamt, right, arith)
//   a, shamt, right, arith     - operand, total amount, direction, sign-fill
//   result / result_valid / result_ready - result handshake
//   busy                       - high while a request is in flight (SHIFT/DONE)
//   step_onehot                - one-hot amount of the current pass, 0 outside SHIFT
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic                right,
  input  logic                arith,
  output logic [WIDTH-1:0]    result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy,
  output logic [ONEHOT_W-1:0] step_onehot
);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     opnd;
  logic [SHAMT_W-1:0]   rem;
  logic                 right_r;
  logic                 arith_r;
  logic [STEP_W-1:0]    step;
  logic [WIDTH-1:0]     shifted;
  logic                 accept;

  // Pass amount: min(remaining, STEP_MAX).
  always_comb begin
    if (rem > SHAMT_W'(STEP_MAX)) begin
      step = STEP_W'(STEP_MAX);
    end else begin
      step = rem[STEP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    step_onehot  = '0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) begin
          accept    = 1'b1;
          state_nxt = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        step_onehot = ONEHOT_W'(1) << step;
        // Last pass when what remains fits in this step exactly.
        if (rem == SHAMT_W'(step)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .operand     (opnd),
    .step_onehot (step_onehot),
    .right       (right_r),
    .arith       (arith_r),
    .shifted     (shifted)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opnd    <= '0;
      rem     <= '0;
      right_r <= 1'b0;
      arith_r <= 1'b0;
    end else if (accept) begin
      opnd    <= a;
      rem     <= shamt;
      right_r <= right;
      arith_r <= arith;
    end else if (state == SHIFT) begin
      opnd <= shifted;
      rem  <= rem - SHAMT_W'(step);
    end
  end

  assign result = opnd;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller for the shifter datapath. It accepts one shift request at a time and splits the total shift amount into passes of at most 7 bits, which is the range a one-hot 3-to-8 amount decode can express. Each pass is applied to an internal operand register, and the result is returned over a valid/ready handshake. The block sits between the ALU issue logic and the shifter step.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, total shift-amount width
STEP_MAX, 7, maximum bits shifted per pass (one-hot amount is 8 bits)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start_valid  input  1  request present
start_ready  output  1  block can accept a request
a  input  WIDTH  operand, sampled on accept
shamt  input  SHAMT_W  total shift amount, sampled on accept
right  input  1  1 = shift right, 0 = shift left
arith  input  1  1 = sign-fill on right shift; ignored on left shift
result  output  WIDTH  shifted operand
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
busy  output  1  high in SHIFT or DONE
step_onehot  output  8  one-hot amount of the current pass; 0 outside SHIFT

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values:
  - State = IDLE.
  - Operand register, remaining count, result, result_valid, step_onehot, busy = 0.
  - start_ready = 1 after reset deasserts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid at a rising edge: latch a, shamt, right, arith.
  - Next state = SHIFT if shamt != 0, else DONE.
- SHIFT, every cycle:
  - step = min(remaining, STEP_MAX).
  - step_onehot = 1 << step (combinational, same cycle).
  - At the edge: operand <= operand shifted by step; remaining <= remaining - step.
  - Vacated bits: left shift fills 0; right logical fills 0; right arithmetic fills the current operand MSB.
  - When remaining - step == 0, next state = DONE.
- DONE:
  - result_valid = 1; result = operand register.
  - Both hold stable until result_ready = 1 at an edge, then next state = IDLE.
- Latency: for shamt = s, result_valid rises ceil(s/7) + 1 cycles after the accept edge. s = 0 gives 1 cycle; s = 31 gives 6 cycles.
- start_ready = 0 in SHIFT and DONE; start_valid is ignored there and no request is queued.
- A new request can be accepted in the cycle after the DONE handshake, which returns the block to IDLE (no same-cycle DONE-to-accept).
- Input changes on a, shamt, right and arith after the accept edge have no effect.
- reset_n low in any state: immediate return to IDLE with reset values. The in-flight request is dropped and no result_valid is produced.
- Width rule: remaining is SHAMT_W bits and never underflows, because step ≤ remaining by construction.

Decomposition:
- Package shift_seq_pkg contains:
  - state enum (IDLE, SHIFT, DONE)
  - STEP_MAX constant
  - step-width localparam (3)
- One sub-module, shift_step. It is purely combinational: inputs operand, step_onehot, right, arith; output is the operand shifted by one pass. The sequencer instantiates it once and registers its output.

Test Plan:
- Right arithmetic, a=0x8000_0001, shamt=31:
  - step_onehot sequence over 5 SHIFT cycles: 0x80, 0x80, 0x80, 0x80, 0x08.
  - Then result=0xFFFF_FFFF, result_valid 6 cycles after accept.
- Left, a=0x0000_000F, shamt=4:
  - One pass with step_onehot=0x10.
  - result=0x0000_00F0 after 2 cycles.
- Right logical, a=0x8000_0000, shamt=8:
  - Passes 0x80 then 0x02.
  - result=0x0080_0000; arith=0 confirms zero fill.
- shamt=0, a=0x1234_5678:
  - No SHIFT cycles; step_onehot stays 0.
  - result=0x1234_5678 one cycle after accept.
- Backpressure, shamt=9:
  - Hold result_ready=0 for 3 cycles in DONE: result and result_valid stay stable, start_ready=0.
  - A start_valid pulse during DONE is ignored.
  - After result_ready=1: IDLE, start_ready=1.
- Reset mid-op:
  - Assert reset_n=0 during the second SHIFT cycle of shamt=20.
  - Asynchronously all outputs return to reset values and state is IDLE.
  - After release, a new request (left, a=1, shamt=1) yields result=0x0000_0002.
